serialmul_io: RTL

//   Parallel<->bit-serial adapter for the bit-serial multiplier array. Accepts one

---
 rtl/serialmul_io_if.sv | 27 ++
 rtl/serialmul_io.sv | 98 +++++++++
 2 files changed

// File: rtl/serialmul_io_if.sv
// Operand, serial-array and result signals of the parallel<->bit-serial multiplier adapter.
// slave is the adapter side; master is the operand source / array / result consumer side.
interface serialmul_io_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 ser_a;
    logic                 ser_sync;
    logic [WIDTH-1:0]     par_b;
    logic                 ser_p;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;

    modport slave (
        input  in_valid, in_a, in_b, ser_p, out_ready,
        output in_ready, ser_a, ser_sync, par_b, out_valid, out_p
    );

    modport master (
        output in_valid, in_a, in_b, ser_p, out_ready,
        input  in_ready, ser_a, ser_sync, par_b, out_valid, out_p
    );
endinterface

// File: rtl/serialmul_io.sv
// Streams A LSB-first to the bit-serial array with B held in parallel, collects the serial product.
// Handshake to out_valid takes 2*WIDTH+ARRAY_LAT+1 cycles; in_ready only in IDLE, result held until out_ready.
module serialmul_io #(
    parameter int WIDTH     = 8,
    parameter int ARRAY_LAT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    serialmul_io_if.slave     bus
);
    localparam int CNT_MAX = 2*WIDTH + ARRAY_LAT - 1;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX);
    localparam logic [CW-1:0] CAP_FIRST = CW'(ARRAY_LAT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 ser_a_q, ser_a_d;
    logic                 ser_sync_q, ser_sync_d;
    logic [WIDTH-1:0]     par_b_q, par_b_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        p_d        = p_q;
        ser_a_d    = 1'b0;
        ser_sync_d = 1'b0;
        par_b_d    = par_b_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Bit 0 leaves now; a_q holds the bits still to be sent.
                    ser_a_d    = bus.in_a[0];
                    ser_sync_d = 1'b1;
                    a_d        = bus.in_a >> 1;
                    par_b_d    = bus.in_b;
                    cnt_d      = '0;
                    p_d        = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (cnt_q >= CAP_FIRST) begin
                    p_d = {bus.ser_p, p_q[2*WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    // Zeros shift in behind A, giving the zero-extended upper half.
                    cnt_d   = cnt_q + CW'(1);
                    ser_a_d = a_q[0];
                    a_d     = a_q >> 1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    par_b_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            p_q        <= '0;
            ser_a_q    <= 1'b0;
            ser_sync_q <= 1'b0;
            par_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            p_q        <= p_d;
            ser_a_q    <= ser_a_d;
            ser_sync_q <= ser_sync_d;
            par_b_q    <= par_b_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_p     = p_q;
    assign bus.ser_a     = ser_a_q;
    assign bus.ser_sync  = ser_sync_q;
    assign bus.par_b     = par_b_q;
endmodule
